// File: rtl/aurora_link_pkg.sv
// ---------------------------------------------------------------------------
// aurora_link_pkg
//   Shared definitions for the Aurora link bring-up controller slice.
//   - state_t / ST_* : FSM state encodings (0..6), also exported on the
//                      controller's debug state port.
//   - RETRY_W        : width of the consecutive-failure counter.
//   - drive_of()     : the (reset_pb, pma_init) pair each state drives onto
//                      the Aurora core.
// ---------------------------------------------------------------------------
package aurora_link_pkg;

  localparam int RETRY_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PB_LEAD   = 3'd1;
  localparam state_t ST_PMA       = 3'd2;
  localparam state_t ST_PB_TRAIL  = 3'd3;
  localparam state_t ST_WAIT_LINK = 3'd4;
  localparam state_t ST_UP        = 3'd5;
  localparam state_t ST_FAILED    = 3'd6;

  // Returns {reset_pb, pma_init} for a given state. FAILED keeps both
  // asserted so the core stays parked in reset until software intervenes.
  function automatic logic [1:0] drive_of(input state_t st);
    logic [1:0] drv;
    case (st)
      ST_IDLE:      drv = 2'b10;
      ST_PB_LEAD:   drv = 2'b10;
      ST_PMA:       drv = 2'b11;
      ST_PB_TRAIL:  drv = 2'b10;
      ST_WAIT_LINK: drv = 2'b00;
      ST_UP:        drv = 2'b00;
      ST_FAILED:    drv = 2'b11;
      default:      drv = 2'b10;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/aurora_dwell_timer.sv
// ---------------------------------------------------------------------------
// aurora_dwell_timer
//   Loadable down-counter shared by every timed state of the bring-up FSM
//   (reset dwells, link timeout, channel-down debounce). Only one of those
//   measurements is live in any state, so one counter serves them all.
// Ports
//   i_clk      : clock
//   i_rst      : asynchronous active-high reset (counter cleared)
//   i_load     : load i_load_val this cycle (wins over i_dec)
//   i_load_val : value to load, normally N-1 for an N-cycle interval
//   i_dec      : decrement by one; holds at zero
//   o_zero     : counter currently reads zero
// ---------------------------------------------------------------------------
module aurora_dwell_timer
  import aurora_link_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority so that a state change and its new interval land on
  // the same edge; decrement saturates at zero so a stale decrement request
  // can never wrap the counter around to a huge value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/aurora_link_bringup_ctrl.sv
// ---------------------------------------------------------------------------
// aurora_link_bringup_ctrl
//   Sequences the Aurora core's reset_pb / pma_init so the 2-lane QSFP GT
//   link comes up cleanly, waits for channel/lane up, and re-runs the
//   sequence on link timeout or on a debounced channel-down. After
//   MAX_RETRIES consecutive failures it parks in FAILED until cleared.
// Ports
//   i_init_clk    : free-running init clock, everything is synchronous to it
//   i_reset       : asynchronous active-high reset
//   i_enable      : level, 1 = bring link up, 0 = hold in IDLE
//   i_clr_fail    : pulse, leaves FAILED (ignored elsewhere)
//   i_lane_up     : per-lane up from the Aurora core (pre-synchronised)
//   i_channel_up  : channel up from the Aurora core (pre-synchronised)
//   o_reset_pb    : Aurora reset_pb
//   o_pma_init    : Aurora pma_init
//   o_link_ready  : high only in UP
//   o_fail        : high only in FAILED
//   o_retry_count : consecutive failed attempts, saturating at 255
//   o_state       : current state encoding (debug)
// ---------------------------------------------------------------------------
module aurora_link_bringup_ctrl
  import aurora_link_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int PB_LEAD       = 128,
  parameter int PMA_HOLD      = 1024,
  parameter int PB_TRAIL      = 128,
  parameter int LINK_TIMEOUT  = 1048576,
  parameter int DOWN_DEBOUNCE = 64,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 21
) (
  input  logic                 i_init_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_clr_fail,
  input  logic [NUM_LANES-1:0] i_lane_up,
  input  logic                 i_channel_up,
  output logic                 o_reset_pb,
  output logic                 o_pma_init,
  output logic                 o_link_ready,
  output logic                 o_fail,
  output logic [RETRY_W-1:0]   o_retry_count,
  output logic [2:0]           o_state
);

  // Every interval is loaded as N-1 on state entry and the state exits on
  // the edge where the counter reads zero, giving a dwell of exactly N.
  localparam logic [CNT_W-1:0] LD_PB_LEAD  = CNT_W'(PB_LEAD - 1);
  localparam logic [CNT_W-1:0] LD_PMA      = CNT_W'(PMA_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_PB_TRAIL = CNT_W'(PB_TRAIL - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_DEBOUNCE = CNT_W'(DOWN_DEBOUNCE - 1);

  // MAX_RETRIES of zero means retry forever, so the limit compare is gated.
  localparam bit                 RETRY_BOUNDED = (MAX_RETRIES != 0);
  localparam logic [RETRY_W-1:0] RETRY_LAST    = RETRY_W'(MAX_RETRIES - 1);

  state_t             r_state;
  logic [RETRY_W-1:0] r_retry_count;
  logic               r_reset_pb;
  logic               r_pma_init;
  logic               r_link_ready;
  logic               r_fail;

  state_t             w_next_state;
  logic [RETRY_W-1:0] w_next_retry;
  logic [RETRY_W-1:0] w_retry_inc;
  logic [1:0]         w_next_drive;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_dec;
  logic               w_zero;
  logic               w_link_ok;
  logic               w_retry_event;

  aurora_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_init_clk),
    .i_rst      (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_link_ok   = i_channel_up & (&i_lane_up);
  assign w_retry_inc = (r_retry_count == {RETRY_W{1'b1}}) ? r_retry_count
                                                          : r_retry_count + 1'b1;

  // Next-state and timer control. Dropping enable overrides everything and
  // forgets the failure history. In WAIT_LINK the link-up test is checked
  // before the timeout so a channel_up arriving on the final timeout cycle
  // still counts as success. In UP any cycle with channel_up reloads the
  // debounce interval, so only an unbroken run of channel-down retries; the
  // lane_up bits are deliberately not watched once the channel is up.
  // Timeouts and debounced drops share one retry path at the bottom, which
  // either restarts the sequence or gives up into FAILED.
  always_comb begin
    w_next_state  = r_state;
    w_next_retry  = r_retry_count;
    w_load        = 1'b0;
    w_load_val    = '0;
    w_dec         = 1'b0;
    w_retry_event = 1'b0;

    if (!i_enable) begin
      w_next_state = ST_IDLE;
      w_next_retry = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next_state = ST_PB_LEAD;
          w_load       = 1'b1;
          w_load_val   = LD_PB_LEAD;
        end
        ST_PB_LEAD: begin
          if (w_zero) begin
            w_next_state = ST_PMA;
            w_load       = 1'b1;
            w_load_val   = LD_PMA;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_PMA: begin
          if (w_zero) begin
            w_next_state = ST_PB_TRAIL;
            w_load       = 1'b1;
            w_load_val   = LD_PB_TRAIL;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_PB_TRAIL: begin
          if (w_zero) begin
            w_next_state = ST_WAIT_LINK;
            w_load       = 1'b1;
            w_load_val   = LD_TIMEOUT;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          if (w_link_ok) begin
            w_next_state = ST_UP;
            w_next_retry = '0;
            w_load       = 1'b1;
            w_load_val   = LD_DEBOUNCE;
          end else if (w_zero) begin
            w_retry_event = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_UP: begin
          if (i_channel_up) begin
            w_load     = 1'b1;
            w_load_val = LD_DEBOUNCE;
          end else if (w_zero) begin
            w_retry_event = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_FAILED: begin
          if (i_clr_fail) begin
            w_next_state = ST_IDLE;
            w_next_retry = '0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_retry = '0;
        end
      endcase

      if (w_retry_event) begin
        w_next_retry = w_retry_inc;
        if (RETRY_BOUNDED && (r_retry_count == RETRY_LAST)) begin
          w_next_state = ST_FAILED;
        end else begin
          w_next_state = ST_PB_LEAD;
          w_load       = 1'b1;
          w_load_val   = LD_PB_LEAD;
        end
      end
    end
  end

  assign w_next_drive = drive_of(w_next_state);

  // State, retry count and all outputs register together, with the outputs
  // decoded from the next state so they switch on the same edge as the
  // state register rather than one cycle behind it. Reset parks the core
  // with reset_pb high and pma_init low.
  always_ff @(posedge i_init_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_retry_count <= '0;
      r_reset_pb    <= 1'b1;
      r_pma_init    <= 1'b0;
      r_link_ready  <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_retry_count <= w_next_retry;
      r_reset_pb    <= w_next_drive[1];
      r_pma_init    <= w_next_drive[0];
      r_link_ready  <= (w_next_state == ST_UP);
      r_fail        <= (w_next_state == ST_FAILED);
    end
  end

  assign o_reset_pb    = r_reset_pb;
  assign o_pma_init    = r_pma_init;
  assign o_link_ready  = r_link_ready;
  assign o_fail        = r_fail;
  assign o_retry_count = r_retry_count;
  assign o_state       = r_state;

endmodule
